ld_st_bank_ctrl: RTL

Controller sitting in front of a bank of M n-bit `LD_ST_Reg` registers; it arbitrates two requesters (A, B) and sequences load, set, clear and read operations into the bank. Each accepted request becomes a single-cycle one-hot strobe on the addressed register's `LD_ST`, `set` or `clr` line, followed by a one-cycle acknowledge. It replaces ad-hoc glue that drove bank control lines directly from multiple sources.

---
 rtl/ld_st_ctrl_pkg.sv | 18 +
 rtl/ld_st_bank_ctrl_if.sv | 38 +++
 rtl/ld_st_rr_arbiter.sv | 42 ++++
 rtl/ld_st_bank_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ld_st_ctrl_pkg.sv
// Shared definitions for the LD_ST register-bank controller: op encoding and FSM state type.
// Optional round-robin arbitration is selected with LD_ST_CTRL_RR_EN (see ld_st_rr_arbiter).
package ld_st_ctrl_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_READ = 2'd0;
  localparam op_t OP_LOAD = 2'd1;
  localparam op_t OP_SET  = 2'd2;
  localparam op_t OP_CLR  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StAck   = 2'd2
  } state_e;

endpackage

// File: rtl/ld_st_bank_ctrl_if.sv
// Requester and bank-side signal bundle for ld_st_bank_ctrl.
// master = requesters plus bank read-back; slave = the controller.
interface ld_st_bank_ctrl_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned M  = 4,
  parameter int unsigned AW = 2
) ();
  import ld_st_ctrl_pkg::*;

  logic           req_a;
  logic           req_b;
  op_t            op_a;
  op_t            op_b;
  logic [AW-1:0]  addr_a;
  logic [AW-1:0]  addr_b;
  logic [N-1:0]   data_a;
  logic [N-1:0]   data_b;
  logic           ack_a;
  logic           ack_b;
  logic           err;
  logic [N-1:0]   rdata;
  logic [M-1:0]   reg_ld_st;
  logic [M-1:0]   reg_set;
  logic [M-1:0]   reg_clr;
  logic [N-1:0]   reg_din;
  logic [M*N-1:0] reg_dout;

  modport master (
    output req_a, req_b, op_a, op_b, addr_a, addr_b, data_a, data_b, reg_dout,
    input  ack_a, ack_b, err, rdata, reg_ld_st, reg_set, reg_clr, reg_din
  );

  modport slave (
    input  req_a, req_b, op_a, op_b, addr_a, addr_b, data_a, data_b, reg_dout,
    output ack_a, ack_b, err, rdata, reg_ld_st, reg_set, reg_clr, reg_din
  );

endinterface

// File: rtl/ld_st_rr_arbiter.sv
// Two-input arbiter. With LD_ST_CTRL_RR_EN a one-bit pointer alternates tie winners;
// without it A has fixed priority and no state exists.
module ld_st_rr_arbiter (
`ifdef LD_ST_CTRL_RR_EN
  input  logic clk,
  input  logic clr,
  input  logic grant_en_i,
`endif
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

`ifdef LD_ST_CTRL_RR_EN
  logic prefer_b_q, prefer_b_d;

  always_comb begin
    gnt_a_o    = req_a_i & (~req_b_i | ~prefer_b_q);
    gnt_b_o    = req_b_i & (~req_a_i | prefer_b_q);
    prefer_b_d = prefer_b_q;
    // After any grant, favour the side that was not just served.
    if (grant_en_i) begin
      prefer_b_d = gnt_a_o;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      prefer_b_q <= 1'b0;
    end else begin
      prefer_b_q <= prefer_b_d;
    end
  end
`else
  always_comb begin
    gnt_a_o = req_a_i;
    gnt_b_o = req_b_i & ~req_a_i;
  end
`endif

endmodule

// File: rtl/ld_st_bank_ctrl.sv
// Sequences READ/LOAD/SET/CLR requests from two requesters into one-hot bank strobes.
// Tie policy depends on LD_ST_CTRL_RR_EN (round-robin when defined, A-first otherwise).
module ld_st_bank_ctrl #(
  parameter int unsigned N  = 4,
  parameter int unsigned M  = 4,
  parameter int unsigned AW = 2
) (
  input  logic              clk,
  input  logic              clr,
  ld_st_bank_ctrl_if.slave  bus_io
);
  import ld_st_ctrl_pkg::*;

  localparam logic [AW:0] NumRegs = (AW + 1)'(M);

  state_e        state_q, state_d;
  op_t           op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [N-1:0]  data_q, data_d;
  logic          win_b_q, win_b_d;

  logic [M-1:0]  reg_ld_st_q, reg_ld_st_d;
  logic [M-1:0]  reg_set_q, reg_set_d;
  logic [M-1:0]  reg_clr_q, reg_clr_d;
  logic [N-1:0]  reg_din_q, reg_din_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          err_q, err_d;
  logic [N-1:0]  rdata_q, rdata_d;

  logic          gnt_a, gnt_b;
  logic          addr_ok;
  logic [M-1:0]  addr_onehot;
  logic [N-1:0]  sel_dout;

  ld_st_rr_arbiter u_arb (
`ifdef LD_ST_CTRL_RR_EN
    .clk        (clk),
    .clr        (clr),
    .grant_en_i ((state_q == StIdle) && (bus_io.req_a || bus_io.req_b)),
`endif
    .req_a_i    (bus_io.req_a),
    .req_b_i    (bus_io.req_b),
    .gnt_a_o    (gnt_a),
    .gnt_b_o    (gnt_b)
  );

  assign addr_ok = {1'b0, addr_q} < NumRegs;

  always_comb begin
    addr_onehot = '0;
    sel_dout    = '0;
    for (int i = 0; i < int'(M); i++) begin
      if (addr_q == AW'(i)) begin
        addr_onehot[i] = 1'b1;
        sel_dout       = bus_io.reg_dout[i*N +: N];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    win_b_d     = win_b_q;
    reg_ld_st_d = '0;
    reg_set_d   = '0;
    reg_clr_d   = '0;
    reg_din_d   = reg_din_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;

    unique case (state_q)
      StIdle: begin
        if (gnt_a || gnt_b) begin
          state_d = StIssue;
          win_b_d = gnt_b;
          op_d    = gnt_b ? bus_io.op_b   : bus_io.op_a;
          addr_d  = gnt_b ? bus_io.addr_b : bus_io.addr_a;
          data_d  = gnt_b ? bus_io.data_b : bus_io.data_a;
        end
      end
      StIssue: begin
        state_d   = StAck;
        reg_din_d = data_q;
        if (addr_ok) begin
          case (op_q)
            OP_LOAD: reg_ld_st_d = addr_onehot;
            OP_SET:  reg_set_d   = addr_onehot;
            OP_CLR:  reg_clr_d   = addr_onehot;
            default: ;
          endcase
        end
      end
      StAck: begin
        state_d = StIdle;
        ack_a_d = ~win_b_q;
        ack_b_d = win_b_q;
        err_d   = ~addr_ok;
        // Bank is stable here: the only write this op could cause is absent for READ.
        if (addr_ok && (op_q == OP_READ)) begin
          rdata_d = sel_dout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      win_b_q     <= 1'b0;
      reg_ld_st_q <= '0;
      reg_set_q   <= '0;
      reg_clr_q   <= '0;
      reg_din_q   <= '0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      win_b_q     <= win_b_d;
      reg_ld_st_q <= reg_ld_st_d;
      reg_set_q   <= reg_set_d;
      reg_clr_q   <= reg_clr_d;
      reg_din_q   <= reg_din_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_io.reg_ld_st = reg_ld_st_q;
  assign bus_io.reg_set   = reg_set_q;
  assign bus_io.reg_clr   = reg_clr_q;
  assign bus_io.reg_din   = reg_din_q;
  assign bus_io.ack_a     = ack_a_q;
  assign bus_io.ack_b     = ack_b_q;
  assign bus_io.err       = err_q;
  assign bus_io.rdata     = rdata_q;

endmodule
